// File: rtl/alu_pkg.sv
// Shared types for the lab ALU responder: mode codes, flag bit positions
// and the sequencing FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      AND = 4'd2,
      OR  = 4'd3,
      XOR = 4'd4,
      SHL = 4'd5,
      SHR = 4'd6,
      MUL = 4'd7,
      DIV = 4'd8,
      MOD = 4'd9
   } mode_e;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      RESP
   } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative shift-add multiplier and restoring divider, one bit per step.
// The *_nxt outputs show the value the current step produces.
module alu_iter_core #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_load,
   input  logic           i_step,
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic           o_last,
   output logic [2*N-1:0] o_prod_nxt,
   output logic [N-1:0]   o_quot_nxt,
   output logic [N-1:0]   o_rem_nxt
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0]  r_cnt;
   logic [2*N-1:0] r_acc;
   logic [2*N-1:0] r_mcand;
   logic [N-1:0]   r_mplier;
   logic [N-1:0]   r_q;
   logic [N-1:0]   r_rem;
   logic [N-1:0]   r_d;

   logic [N:0]     w_sh;
   logic [N:0]     w_diff;
   logic           w_fit;

   // Partial remainder never exceeds 2*d, so bit N of the difference
   // is a reliable borrow indicator.
   always_comb begin
      o_prod_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_sh       = {r_rem, r_q[N-1]};
      w_diff     = w_sh - {1'b0, r_d};
      w_fit      = ~w_diff[N];
      o_quot_nxt = {r_q[N-2:0], w_fit};
      o_rem_nxt  = w_fit ? w_diff[N-1:0] : w_sh[N-1:0];
      o_last     = (r_cnt == CW'(1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_q      <= '0;
         r_rem    <= '0;
         r_d      <= '0;
      end else if (i_load) begin
         r_cnt    <= CW'(N);
         r_acc    <= '0;
         r_mcand  <= {{N{1'b0}}, i_a};
         r_mplier <= i_b;
         r_q      <= i_a;
         r_rem    <= '0;
         r_d      <= i_b;
      end else if (i_step) begin
         r_cnt    <= r_cnt - CW'(1);
         r_acc    <= o_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_q      <= o_quot_nxt;
         r_rem    <= o_rem_nxt;
      end
   end

endmodule

// File: rtl/alu_responder.sv
// Request/response ALU engine: FSM, single-cycle datapath, flag generation
// and registered response outputs; mul/div/mod run in alu_iter_core.
module alu_responder
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_mode,
   input  logic [N-1:0] req_a,
   input  logic [N-1:0] req_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic         rsp_err,
   output logic         busy
);

   state_e r_state;
   state_e w_next;

   logic [3:0]     r_mode;
   logic [N-1:0]   r_result;
   logic [3:0]     r_flags;
   logic           r_err;

   logic           w_accept;
   logic           w_step;
   logic           w_last;
   logic [2*N-1:0] w_prod_nxt;
   logic [N-1:0]   w_quot_nxt;
   logic [N-1:0]   w_rem_nxt;

   logic [N:0]     w_sum;
   logic [N-1:0]   w_sres;
   logic           w_sc;
   logic           w_sv;
   logic           w_serr;
   logic           w_iter;
   logic [3:0]     w_sflags;

   logic [N-1:0]   w_ires;
   logic           w_ihi;
   logic [3:0]     w_iflags;

   assign w_accept = req_valid && (r_state == IDLE);

   alu_iter_core #(.N(N)) u_core (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_step     (w_step),
      .i_a        (req_a),
      .i_b        (req_b),
      .o_last     (w_last),
      .o_prod_nxt (w_prod_nxt),
      .o_quot_nxt (w_quot_nxt),
      .o_rem_nxt  (w_rem_nxt)
   );

   always_comb begin
      w_sum  = '0;
      w_sres = '0;
      w_sc   = 1'b0;
      w_sv   = 1'b0;
      w_serr = 1'b0;
      w_iter = 1'b0;
      case (mode_e'(req_mode))
         ADD: begin
            w_sum  = {1'b0, req_a} + {1'b0, req_b};
            w_sres = w_sum[N-1:0];
            w_sc   = w_sum[N];
            w_sv   = (req_a[N-1] == req_b[N-1])
                  && (w_sres[N-1] != req_a[N-1]);
         end
         SUB: begin
            w_sum  = {1'b0, req_a} + {1'b0, ~req_b}
                   + {{N{1'b0}}, 1'b1};
            w_sres = w_sum[N-1:0];
            w_sc   = w_sum[N];
            w_sv   = (req_a[N-1] != req_b[N-1])
                  && (w_sres[N-1] != req_a[N-1]);
         end
         AND: w_sres = req_a & req_b;
         OR:  w_sres = req_a | req_b;
         XOR: w_sres = req_a ^ req_b;
         SHL: begin
            w_sres = {req_a[N-2:0], 1'b0};
            w_sc   = req_a[N-1];
         end
         SHR: begin
            w_sres = {1'b0, req_a[N-1:1]};
            w_sc   = req_a[0];
         end
         MUL: w_iter = 1'b1;
         DIV, MOD: begin
            if (req_b == '0) begin
               w_sres = '1;
               w_sv   = 1'b1;
            end else begin
               w_iter = 1'b1;
            end
         end
         default: w_serr = 1'b1;
      endcase

      w_sflags = '0;
      if (!w_serr) begin
         w_sflags[FLG_N] = w_sres[N-1];
         w_sflags[FLG_Z] = (w_sres == '0);
         w_sflags[FLG_C] = w_sc;
         w_sflags[FLG_V] = w_sv;
      end
   end

   // Completion of an iterative op uses the final step's values directly
   // so the response lands on the same edge as the last step.
   always_comb begin
      w_ihi  = 1'b0;
      w_ires = w_rem_nxt;
      if (r_mode == MUL) begin
         w_ires = w_prod_nxt[N-1:0];
         w_ihi  = |w_prod_nxt[2*N-1:N];
      end else if (r_mode == DIV) begin
         w_ires = w_quot_nxt;
      end
      w_iflags        = '0;
      w_iflags[FLG_N] = w_ires[N-1];
      w_iflags[FLG_Z] = (w_ires == '0);
      w_iflags[FLG_C] = w_ihi;
      w_iflags[FLG_V] = w_ihi;
   end

   always_comb begin
      w_next = r_state;
      w_step = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) w_next = w_iter ? ITER : RESP;
         end
         ITER: begin
            w_step = 1'b1;
            if (w_last) w_next = RESP;
         end
         RESP: begin
            if (rsp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode   <= '0;
         r_result <= '0;
         r_flags  <= '0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_mode <= req_mode;
         if (!w_iter) begin
            r_result <= w_sres;
            r_flags  <= w_sflags;
            r_err    <= w_serr;
         end
      end else if (r_state == ITER && w_last) begin
         r_result <= w_ires;
         r_flags  <= w_iflags;
         r_err    <= 1'b0;
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign rsp_valid  = (r_state == RESP);
   assign busy       = (r_state != IDLE);
   assign rsp_result = r_result;
   assign rsp_flags  = r_flags;
   assign rsp_err    = r_err;

endmodule
